// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the instruction fetch unit
package fetch_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int INSTR_W_DEF = 16;
  localparam int DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_occupancy_counter.sv
// rtl/fetch_occupancy_counter.sv - prefetch register occupancy tracker
module fetch_occupancy_counter
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] occupancy_o
);

  logic [OCC_W-1:0] occ_q, occ_d;

  // Clear wins; a write and a consume in the same cycle cancel; consume when empty is dropped.
  always_comb begin
    occ_d = occ_q;
    if (clr_i) begin
      occ_d = '0;
    end else if (inc_i && !dec_i) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (dec_i && !inc_i && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - sequential instruction fetcher feeding a small prefetch register
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     consume,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_W-1:0]       imem_rdata,
  output logic                     ipr_wr_en,
  output logic [INSTR_W-1:0]       ipr_instruction,
  output logic [ADDR_W-1:0]        ipr_instr_ptr,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [ADDR_W-1:0]        fetch_pc
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               wr_q, wr_d;
  logic [SUM_W-1:0]   in_flight;
  logic               room_idle;
  logic               room_ack;

  // Entries held plus the write already on its way; an ack taken this cycle adds one more.
  assign in_flight = SUM_W'(occupancy) + SUM_W'(wr_q);
  assign room_idle = fetch_en && (in_flight < SUM_W'(DEPTH));
  assign room_ack  = fetch_en && ((in_flight + SUM_W'(1)) < SUM_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    instr_d = instr_q;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (room_idle) begin
          state_d = REQ;
          addr_d  = pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_ack ? IDLE : FLUSH;
        end else if (imem_ack) begin
          wr_d    = 1'b1;
          instr_d = imem_rdata;
          ptr_d   = addr_q;
          pc_d    = addr_q + ADDR_W'(1);
          if (room_ack) begin
            addr_d = addr_q + ADDR_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        // The request stays on the bus until memory answers; its data is dropped.
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
      instr_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      instr_q <= instr_d;
      wr_q    <= wr_d;
    end
  end

  fetch_occupancy_counter #(
    .DEPTH (DEPTH)
  ) u_occupancy (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (redirect),
    .inc_i       (wr_q),
    .dec_i       (consume),
    .occupancy_o (occupancy)
  );

  assign imem_req        = (state_q != IDLE);
  assign imem_addr       = addr_q;
  assign ipr_wr_en       = wr_q;
  assign ipr_instruction = instr_q;
  assign ipr_instr_ptr   = ptr_q;
  assign fetch_pc        = pc_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the instruction word-address width.
REQ-002 Parameter INSTR_W, default 16, SHALL set the instruction width.
REQ-003 Parameter DEPTH, default 4, SHALL set the downstream prefetch register capacity in entries.
REQ-004 clk  input  1  SHALL be the clock; all state updates on rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 fetch_en  input  1  SHALL permit new memory requests when high.
REQ-007 redirect  input  1  SHALL be a one-cycle branch/jump pulse.
REQ-008 redirect_pc  input  ADDR_W  SHALL be the new fetch address, sampled when redirect=1.
REQ-009 consume  input  1  SHALL indicate the decoder removed one prefetch entry this cycle.
REQ-010 imem_req  output  1  SHALL be the instruction-memory request valid.
REQ-011 imem_addr  output  ADDR_W  SHALL be the requested word address.
REQ-012 imem_ack  input  1  SHALL mark that imem_rdata is valid and the request is complete.
REQ-013 imem_rdata  input  INSTR_W  SHALL carry the fetched instruction.
REQ-014 ipr_wr_en  output  1  SHALL be a one-cycle write strobe to the prefetch register.
REQ-015 ipr_instruction  output  INSTR_W  SHALL carry the instruction being written.
REQ-016 ipr_instr_ptr  output  ADDR_W  SHALL carry the word address of that instruction.
REQ-017 occupancy  output  clog2(DEPTH)+1  SHALL report valid prefetch entries.
REQ-018 fetch_pc  output  ADDR_W  SHALL report the next address to be requested.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, FLUSH.
REQ-020 IDLE->REQ SHALL occur when fetch_en=1, redirect=0, and occupancy + ipr_wr_en < DEPTH; imem_req=1 and imem_addr=fetch_pc the following cycle.
REQ-021 In REQ, imem_req and imem_addr SHALL hold stable until imem_ack=1, regardless of fetch_en or consume.
REQ-022 On imem_ack in REQ, imem_rdata and imem_addr SHALL be registered to ipr_instruction/ipr_instr_ptr with ipr_wr_en=1 exactly one cycle later.
REQ-023 On imem_ack in REQ, fetch_pc SHALL increment by 1, wrapping modulo 2^ADDR_W (max address -> 0).
REQ-024 On imem_ack in REQ, the FSM SHALL stay in REQ with the incremented address if the REQ-020 condition still holds (counting the pending write); otherwise it SHALL return to IDLE with imem_req=0.
REQ-025 occupancy SHALL +1 on ipr_wr_en, -1 on consume, and stay unchanged when both occur; consume at occupancy 0 SHALL be ignored.
REQ-026 occupancy SHALL never exceed DEPTH; the issue rule SHALL guarantee this.
REQ-027 redirect SHALL have top priority: fetch_pc<=redirect_pc, occupancy<=0, and any ipr_wr_en due next cycle suppressed.
REQ-028 redirect in REQ without same-cycle imem_ack SHALL move to FLUSH; imem_req/imem_addr remain held; the returning ack's data is discarded (no ipr_wr_en); then IDLE.
REQ-029 redirect in the same cycle as imem_ack SHALL discard that data and move to IDLE.
REQ-030 redirect in FLUSH SHALL update fetch_pc only and remain in FLUSH.
REQ-031 fetch_en=0 SHALL block new requests only; an outstanding request SHALL complete normally.

Reset
REQ-032 While rst=0: state IDLE; fetch_pc, imem_addr, ipr_instruction, ipr_instr_ptr, occupancy = 0; imem_req, ipr_wr_en = 0.
REQ-033 Reset during an outstanding request SHALL abandon it; a later stray imem_ack in IDLE SHALL be ignored.

Structure
REQ-034 The state enum and default widths (ADDR_W=13, INSTR_W=16, DEPTH=4) SHALL live in shared package fetch_pkg.
REQ-035 The occupancy up/down/clear logic SHALL be sub-module fetch_occupancy_counter; everything else is flat.

Verification
REQ-036 Reset, fetch_en=1, zero-wait ack -> addresses 0,1,2,3 issued; ipr_wr_en four times with ptr 0..3; occupancy 4; imem_req then drops.
REQ-037 occupancy 4, one consume pulse -> exactly one new request at address 4; occupancy returns to 4.
REQ-038 Request at 0x005 outstanding, redirect_pc=0x100 before ack; ack after 3 cycles -> no ipr_wr_en; next request address 0x100; occupancy 0.
REQ-039 fetch_pc=0x1FFF, ack -> ipr_instr_ptr=0x1FFF, next imem_addr=0x0000.
REQ-040 ipr_wr_en and consume in the same cycle at occupancy 2 -> occupancy stays 2; consume at 0 -> stays 0.
REQ-041 rst asserted mid-wait, deasserted, stray imem_ack -> no ipr_wr_en, all outputs at reset values.
